// File: rtl/wb_excp_commit_pkg.sv
// rtl/wb_excp_commit_pkg.sv - shared encodings for the writeback commit controller
// Purpose: CSR op encoding, exception codes, ms_excp bit positions, CSR numbers
//          and the commit FSM state type.
// Ports:   none (package).
package wb_excp_commit_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RD   = 2'b01,
    CSR_OP_WR   = 2'b10,
    CSR_OP_XCHG = 2'b11
  } csr_op_e;

  // Bit positions inside ms_excp = {ale, sys, brk, ine, adef}
  localparam int EXCP_ADEF = 0;
  localparam int EXCP_INE  = 1;
  localparam int EXCP_BRK  = 2;
  localparam int EXCP_SYS  = 3;
  localparam int EXCP_ALE  = 4;
  localparam int EXCP_W    = 5;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [2:0] ESUBCODE_NONE = 3'd0;

  localparam logic [13:0] CSR_CRMD   = 14'h0000;
  localparam logic [13:0] CSR_PRMD   = 14'h0001;
  localparam logic [13:0] CSR_ECFG   = 14'h0004;
  localparam logic [13:0] CSR_ESTAT  = 14'h0005;
  localparam logic [13:0] CSR_ERA    = 14'h0006;
  localparam logic [13:0] CSR_EENTRY = 14'h000C;
  localparam logic [13:0] CSR_SAVE0  = 14'h0030;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } commit_state_e;

endpackage

// File: rtl/wb_excp_commit_excp_prio_enc.sv
// rtl/wb_excp_commit_excp_prio_enc.sv - exception priority encoder
// Purpose: picks the highest-priority cause among the interrupt and the
//          instruction's exception bits (INT > ADEF > INE > SYS > BRK > ALE).
// Ports:   int_req  in  1  pending interrupt for the resident instruction
//          excp_vec in  5  {ale, sys, brk, ine, adef}
//          any      out 1  some cause present
//          ecode    out 6  exception code of the winner (0 when none)
//          esubcode out 3  exception subcode of the winner
module excp_prio_enc
  import wb_excp_commit_pkg::*;
(
  input  logic               int_req,
  input  logic [EXCP_W-1:0]  excp_vec,
  output logic               any,
  output logic [5:0]         ecode,
  output logic [2:0]         esubcode
);

  always_comb begin
    any      = 1'b1;
    ecode    = ECODE_INT;
    esubcode = ESUBCODE_NONE;
    if (int_req) begin
      ecode = ECODE_INT;
    end else if (excp_vec[EXCP_ADEF]) begin
      ecode = ECODE_ADEF;
    end else if (excp_vec[EXCP_INE]) begin
      ecode = ECODE_INE;
    end else if (excp_vec[EXCP_SYS]) begin
      ecode = ECODE_SYS;
    end else if (excp_vec[EXCP_BRK]) begin
      ecode = ECODE_BRK;
    end else if (excp_vec[EXCP_ALE]) begin
      ecode = ECODE_ALE;
    end else begin
      any   = 1'b0;
      ecode = 6'h00;
    end
  end

endmodule

// File: rtl/wb_excp_commit.sv
// rtl/wb_excp_commit.sv - writeback-stage commit, CSR access and exception flush
// Purpose: holds one retiring instruction, issues its CSR read/write and GR
//          writeback, turns exceptions/ertn/interrupt into one-cycle flush
//          pulses and then holds a registered PC redirect until fetch takes it.
// Ports:   clk, reset (sync, active-high)
//          ms_*            in   instruction offered by MEM, ws_allowin out
//          csr_*           out  CSR access, csr_rdata in (combinational)
//          excp_flush, ertn_flush, ecode, esubcode, epc  out  flush report
//          era, eentry, has_int  in  from the CSR file
//          rf_we, rf_waddr, rf_wdata  out  GR writeback
//          ws_flush        out  kill younger instructions
//          redirect_valid/redirect_pc out, redirect_ready in  fetch redirect
module wb_excp_commit
  import wb_excp_commit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_to_ws_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_rj,
  input  logic [31:0] ms_rkd,
  input  logic        ms_gr_we,
  input  logic [4:0]  ms_dest,
  input  logic [31:0] ms_result,
  input  logic [4:0]  ms_excp,
  input  logic        ms_ertn,
  output logic        csr_we,
  output logic [13:0] csr_num,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  input  logic [31:0] csr_rdata,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [2:0]  esubcode,
  output logic [31:0] epc,
  input  logic [31:0] era,
  input  logic [31:0] eentry,
  input  logic        has_int,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        ws_flush,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc
);

  logic        ws_valid;
  logic [31:0] ws_pc;
  logic [1:0]  ws_csr_op;
  logic [13:0] ws_csr_num;
  logic [31:0] ws_rj;
  logic [31:0] ws_rkd;
  logic        ws_gr_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic [4:0]  ws_excp_vec;
  logic        ws_ertn_bit;

  commit_state_e state, state_n;

  logic        ws_int;
  logic        ws_excp;
  logic        ws_ertn;
  logic        flush_now;
  logic        is_csr_write;
  logic        ws_accept;
  logic [5:0]  enc_ecode;
  logic [2:0]  enc_esubcode;

  // The captured fields linger after commit; only ws_valid makes them live.
  assign ws_int = ws_valid && has_int;

  excp_prio_enc u_excp_prio_enc (
    .int_req  (ws_int),
    .excp_vec (ws_valid ? ws_excp_vec : 5'b0),
    .any      (ws_excp),
    .ecode    (enc_ecode),
    .esubcode (enc_esubcode)
  );

  assign ws_ertn   = ws_valid && ws_ertn_bit && !ws_excp;
  assign flush_now = ws_excp || ws_ertn;
  assign ws_accept = ms_to_ws_valid && ws_allowin;

  // WB register: every resident instruction commits in its single WB cycle,
  // so ws_valid simply follows the accept of the previous cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ws_valid    <= 1'b0;
      ws_pc       <= '0;
      ws_csr_op   <= CSR_OP_NONE;
      ws_csr_num  <= '0;
      ws_rj       <= '0;
      ws_rkd      <= '0;
      ws_gr_we    <= 1'b0;
      ws_dest     <= '0;
      ws_result   <= '0;
      ws_excp_vec <= '0;
      ws_ertn_bit <= 1'b0;
    end else begin
      ws_valid <= ws_accept;
      if (ws_accept) begin
        ws_pc       <= ms_pc;
        ws_csr_op   <= ms_csr_op;
        ws_csr_num  <= ms_csr_num;
        ws_rj       <= ms_rj;
        ws_rkd      <= ms_rkd;
        ws_gr_we    <= ms_gr_we;
        ws_dest     <= ms_dest;
        ws_result   <= ms_result;
        ws_excp_vec <= ms_excp;
        ws_ertn_bit <= ms_ertn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n        = state;
    ws_allowin     = 1'b0;
    redirect_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ws_allowin = !flush_now;
        if (flush_now) begin
          state_n = ST_REDIR;
        end
      end
      ST_REDIR: begin
        redirect_valid = 1'b1;
        if (redirect_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Target is sampled from the CSR file in the flush cycle and then frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      redirect_pc <= '0;
    end else if (state == ST_IDLE && flush_now) begin
      redirect_pc <= ws_excp ? eentry : era;
    end
  end

  assign excp_flush = ws_excp;
  assign ertn_flush = ws_ertn;
  assign ecode      = enc_ecode;
  assign esubcode   = enc_esubcode;
  assign epc        = ws_excp ? ws_pc : 32'h0;
  assign ws_flush   = flush_now || (state == ST_REDIR);

  assign is_csr_write = (ws_csr_op == CSR_OP_WR) || (ws_csr_op == CSR_OP_XCHG);
  assign csr_we       = ws_valid && !flush_now && is_csr_write;
  assign csr_num      = ws_csr_num;
  assign csr_wmask    = !csr_we ? 32'h0 :
                        (ws_csr_op == CSR_OP_XCHG) ? ws_rj : 32'hFFFF_FFFF;
  assign csr_wdata    = csr_we ? ws_rkd : 32'h0;

  // CSR ops return the pre-write value, read combinationally this cycle.
  assign rf_we    = ws_valid && ws_gr_we && !ws_excp;
  assign rf_waddr = ws_dest;
  assign rf_wdata = (ws_csr_op != CSR_OP_NONE) ? csr_rdata : ws_result;

endmodule

// File: tb/tb_wb_excp_commit.sv
// tb/tb_wb_excp_commit.sv - self-checking bench for wb_excp_commit
module tb_wb_excp_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;
  logic [31:0] ms_rj;
  logic [31:0] ms_rkd;
  logic        ms_gr_we;
  logic [4:0]  ms_dest;
  logic [31:0] ms_result;
  logic [4:0]  ms_excp;
  logic        ms_ertn;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        excp_flush;
  logic        ertn_flush;
  logic [5:0]  ecode;
  logic [2:0]  esubcode;
  logic [31:0] epc;
  logic [31:0] era;
  logic [31:0] eentry;
  logic        has_int;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_flush;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wb_excp_commit dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num),
    .ms_rj(ms_rj), .ms_rkd(ms_rkd), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
    .ms_result(ms_result), .ms_excp(ms_excp), .ms_ertn(ms_ertn),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush), .ecode(ecode),
    .esubcode(esubcode), .epc(epc), .era(era), .eentry(eentry),
    .has_int(has_int), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ws_flush(ws_flush), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ms_to_ws_valid = 1'b0;
    ms_pc = 32'h0; ms_csr_op = 2'b00; ms_csr_num = 14'h0;
    ms_rj = 32'h0; ms_rkd = 32'h0; ms_gr_we = 1'b0; ms_dest = 5'd0;
    ms_result = 32'h0; ms_excp = 5'b0; ms_ertn = 1'b0;
    csr_rdata = 32'h0; era = 32'h0; eentry = 32'h0;
    has_int = 1'b0; redirect_ready = 1'b0;
  endtask

  // Cause ranking: interrupt first, then adef, ine, sys, brk, ale.
  function automatic void ref_cause(input logic v, input logic intr, input logic [4:0] ex,
                                    output logic any, output logic [5:0] code);
    logic [14:0] order;
    logic [29:0] codes;
    logic [2:0]  b;
    order = {3'd4, 3'd2, 3'd3, 3'd1, 3'd0};
    codes = {6'h09, 6'h0C, 6'h0B, 6'h0D, 6'h08};
    any  = 1'b0;
    code = 6'h00;
    if (v && intr) begin
      any = 1'b1;
    end else if (v) begin
      for (int k = 0; k < 5; k++) begin
        b = order[k*3 +: 3];
        if (!any && ex[b]) begin
          any  = 1'b1;
          code = codes[k*6 +: 6];
        end
      end
    end
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        gr_we;
    logic [31:0] res;
    logic [4:0]  ex;
    logic        ertn;
    logic        intr;
    logic [31:0] rdata;
    logic        e_excp;
    logic        e_ertn;
    logic [5:0]  e_ecode;
    logic        e_csr_we;
    logic [31:0] e_wmask;
    logic [31:0] e_wdata;
    logic        e_rf_we;
    logic [31:0] e_rf_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] rj;
    logic [31:0] rkd;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] res;
    logic [4:0]  ex;
    logic        ertn;
  } instr_t;

  vec_t   vecs[14];
  instr_t m_ins;
  logic   m_v, m_redir;
  logic [31:0] m_rpc;
  logic   e_any, e_ertn, e_flush, e_allow, e_wr;
  logic [5:0] e_code;
  logic [31:0] pc_i;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b10, 14'h030, 32'h0,  32'h1234, 1'b1, 32'h0,    5'b00000, 1'b0, 1'b0, 32'hAA,   1'b0, 1'b0, 6'h00, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 32'hAA};
    vecs[1]  = '{2'b11, 14'h030, 32'hFF, 32'h5A5A, 1'b1, 32'h0,    5'b00000, 1'b0, 1'b0, 32'h77,   1'b0, 1'b0, 6'h00, 1'b1, 32'hFF,        32'h5A5A, 1'b1, 32'h77};
    vecs[2]  = '{2'b01, 14'h005, 32'h0,  32'h0,    1'b1, 32'h0,    5'b00000, 1'b0, 1'b0, 32'hBEEF, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0,         32'h0,    1'b1, 32'hBEEF};
    vecs[3]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'hCAFE, 5'b00000, 1'b0, 1'b0, 32'h1111, 1'b0, 1'b0, 6'h00, 1'b0, 32'h0,         32'h0,    1'b1, 32'hCAFE};
    vecs[4]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'h11,   5'b11000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 6'h0B, 1'b0, 32'h0,         32'h0,    1'b0, 32'h11};
    vecs[5]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'h11,   5'b11111, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 6'h08, 1'b0, 32'h0,         32'h0,    1'b0, 32'h11};
    vecs[6]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'h11,   5'b11110, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 6'h0D, 1'b0, 32'h0,         32'h0,    1'b0, 32'h11};
    vecs[7]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'h11,   5'b10100, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 6'h0C, 1'b0, 32'h0,         32'h0,    1'b0, 32'h11};
    vecs[8]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b1, 32'h11,   5'b10000, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 6'h09, 1'b0, 32'h0,         32'h0,    1'b0, 32'h11};
    vecs[9]  = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b0, 32'h0,    5'b00000, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 6'h00, 1'b0, 32'h0,         32'h0,    1'b0, 32'h0};
    vecs[10] = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b0, 32'h0,    5'b00000, 1'b1, 1'b1, 32'h0,    1'b1, 1'b0, 6'h00, 1'b0, 32'h0,         32'h0,    1'b0, 32'h0};
    vecs[11] = '{2'b10, 14'h030, 32'h0,  32'h99,   1'b1, 32'h0,    5'b00100, 1'b0, 1'b0, 32'h55,   1'b1, 1'b0, 6'h0C, 1'b0, 32'h0,         32'h0,    1'b0, 32'h55};
    vecs[12] = '{2'b00, 14'h000, 32'h0,  32'h0,    1'b0, 32'h0,    5'b00010, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 6'h0D, 1'b0, 32'h0,         32'h0,    1'b0, 32'h0};
    vecs[13] = '{2'b11, 14'h004, 32'hF0, 32'h3,    1'b1, 32'h0,    5'b00000, 1'b0, 1'b1, 32'h66,   1'b1, 1'b0, 6'h00, 1'b0, 32'h0,         32'h0,    1'b0, 32'h66};

    // ---------------- reset state ----------------
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_allowin", 32'(ws_allowin), 32'd1);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_ws_flush", 32'(ws_flush), 32'd0);
    chk("rst_excp_flush", 32'(excp_flush), 32'd0);
    chk("rst_ertn_flush", 32'(ertn_flush), 32'd0);
    chk("rst_csr_we", 32'(csr_we), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_epc", epc, 32'h0);

    // ---------------- table-driven single instructions ----------------
    for (int i = 0; i < 14; i++) begin
      pc_i = 32'h1C00_0100 + 32'(i * 16);
      tick();
      idle_inputs();
      ms_to_ws_valid = 1'b1;
      ms_pc = pc_i; ms_csr_op = vecs[i].op; ms_csr_num = vecs[i].num;
      ms_rj = vecs[i].rj; ms_rkd = vecs[i].rkd; ms_gr_we = vecs[i].gr_we;
      ms_dest = 5'd7; ms_result = vecs[i].res; ms_excp = vecs[i].ex; ms_ertn = vecs[i].ertn;
      @(negedge clk);
      chk($sformatf("v%0d_load_allowin", i), 32'(ws_allowin), 32'd1);

      tick();
      idle_inputs();
      has_int = vecs[i].intr; csr_rdata = vecs[i].rdata;
      era = 32'h1C00_0200; eentry = 32'h1C00_8000; redirect_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d_excp_flush", i), 32'(excp_flush), 32'(vecs[i].e_excp));
      chk($sformatf("v%0d_ertn_flush", i), 32'(ertn_flush), 32'(vecs[i].e_ertn));
      chk($sformatf("v%0d_csr_we", i), 32'(csr_we), 32'(vecs[i].e_csr_we));
      chk($sformatf("v%0d_csr_num", i), 32'(csr_num), 32'(vecs[i].num));
      if (vecs[i].e_csr_we) begin
        chk($sformatf("v%0d_wmask", i), csr_wmask, vecs[i].e_wmask);
        chk($sformatf("v%0d_wdata", i), csr_wdata, vecs[i].e_wdata);
      end
      chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].e_rf_we));
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_rf_wdata);
      chk($sformatf("v%0d_rf_waddr", i), 32'(rf_waddr), 32'd7);
      chk($sformatf("v%0d_ws_flush", i), 32'(ws_flush), 32'(vecs[i].e_excp || vecs[i].e_ertn));
      chk($sformatf("v%0d_allowin", i), 32'(ws_allowin), 32'(!(vecs[i].e_excp || vecs[i].e_ertn)));
      if (vecs[i].e_excp) begin
        chk($sformatf("v%0d_ecode", i), 32'(ecode), 32'(vecs[i].e_ecode));
        chk($sformatf("v%0d_esubcode", i), 32'(esubcode), 32'd0);
        chk($sformatf("v%0d_epc", i), epc, pc_i);
      end

      tick();
      has_int = 1'b0; era = 32'h0; eentry = 32'h0;
      @(negedge clk);
      chk($sformatf("v%0d_redir_valid", i), 32'(redirect_valid), 32'(vecs[i].e_excp || vecs[i].e_ertn));
      chk($sformatf("v%0d_pulse_once", i), 32'(excp_flush || ertn_flush), 32'd0);
      if (vecs[i].e_excp || vecs[i].e_ertn)
        chk($sformatf("v%0d_redir_pc", i), redirect_pc, vecs[i].e_excp ? 32'h1C00_8000 : 32'h1C00_0200);

      tick();
      redirect_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_back_idle", i), 32'({redirect_valid, ws_allowin}), 32'b01);
    end

    // ---------------- back-to-back csrwr, 0-bubble ----------------
    tick();
    idle_inputs();
    ms_to_ws_valid = 1'b1; ms_csr_op = 2'b10; ms_csr_num = 14'h030;
    ms_rkd = 32'h1000; ms_gr_we = 1'b1; ms_dest = 5'd3;
    @(negedge clk);
    chk("b2b_allowin0", 32'(ws_allowin), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      ms_rkd = 32'h1000 + 32'(k);
      csr_rdata = 32'h100 + 32'(k);
      @(negedge clk);
      chk($sformatf("b2b_allowin%0d", k), 32'(ws_allowin), 32'd1);
      chk($sformatf("b2b_csr_we%0d", k), 32'(csr_we), 32'd1);
      chk($sformatf("b2b_wdata%0d", k), csr_wdata, 32'h1000 + 32'(k - 1));
      chk($sformatf("b2b_rf_wdata%0d", k), rf_wdata, 32'h100 + 32'(k));
    end
    tick();
    ms_to_ws_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_wdata", csr_wdata, 32'h1003);
    tick();
    @(negedge clk);
    chk("b2b_drained_csr_we", 32'(csr_we), 32'd0);

    // ---------------- redirect hold, dropped offers, interrupt in REDIR ----------------
    tick();
    idle_inputs();
    ms_to_ws_valid = 1'b1; ms_pc = 32'h1C00_0300; ms_excp = 5'b01000; ms_gr_we = 1'b1;
    tick();
    idle_inputs();
    eentry = 32'h1C00_8000;
    @(negedge clk);
    chk("hold_pulse", 32'(excp_flush), 32'd1);
    chk("hold_ecode", 32'(ecode), 32'h0B);
    for (int k = 0; k < 3; k++) begin
      tick();
      eentry = 32'hDEAD_0000 + 32'(k);
      ms_to_ws_valid = 1'b1; ms_gr_we = 1'b1; ms_excp = 5'b0;
      has_int = 1'b1; redirect_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 32'(redirect_valid), 32'd1);
      chk($sformatf("hold%0d_pc", k), redirect_pc, 32'h1C00_8000);
      chk($sformatf("hold%0d_allowin", k), 32'(ws_allowin), 32'd0);
      chk($sformatf("hold%0d_ws_flush", k), 32'(ws_flush), 32'd1);
      chk($sformatf("hold%0d_no_pulse", k), 32'(excp_flush), 32'd0);
    end
    tick();
    ms_to_ws_valid = 1'b0; redirect_ready = 1'b1;
    @(negedge clk);
    chk("hold_accept_valid", 32'(redirect_valid), 32'd1);
    tick();
    redirect_ready = 1'b0;
    @(negedge clk);
    chk("hold_exit_valid", 32'(redirect_valid), 32'd0);
    chk("hold_exit_allowin", 32'(ws_allowin), 32'd1);
    chk("hold_int_waits", 32'(excp_flush), 32'd0);
    chk("hold_dropped_rf_we", 32'(rf_we), 32'd0);
    tick();
    ms_to_ws_valid = 1'b1; ms_pc = 32'h1C00_0400; ms_gr_we = 1'b1;
    tick();
    ms_to_ws_valid = 1'b0; eentry = 32'h1C00_8000;
    @(negedge clk);
    chk("int_next_instr_flush", 32'(excp_flush), 32'd1);
    chk("int_next_instr_ecode", 32'(ecode), 32'h00);
    chk("int_next_instr_epc", epc, 32'h1C00_0400);
    tick();
    has_int = 1'b0; redirect_ready = 1'b1;
    tick();
    idle_inputs();

    // ---------------- reset during REDIR ----------------
    tick();
    ms_to_ws_valid = 1'b1; ms_ertn = 1'b1;
    tick();
    idle_inputs();
    era = 32'h1C00_0200;
    @(negedge clk);
    chk("rr_ertn_pulse", 32'(ertn_flush), 32'd1);
    tick();
    @(negedge clk);
    chk("rr_redir_pc", redirect_pc, 32'h1C00_0200);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rr_valid", 32'(redirect_valid), 32'd0);
    chk("rr_ws_flush", 32'(ws_flush), 32'd0);
    chk("rr_allowin", 32'(ws_allowin), 32'd1);
    chk("rr_redir_pc_clr", redirect_pc, 32'h0);

    // ---------------- randomized run against a transaction model ----------------
    m_v = 1'b0; m_redir = 1'b0; m_rpc = 32'h0;
    m_ins = '{32'h0, 2'b00, 14'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'b0, 1'b0};
    for (int c = 0; c < 2000; c++) begin
      tick();
      ms_to_ws_valid = ($urandom_range(0, 3) != 0);
      ms_pc = $urandom; ms_csr_op = 2'($urandom); ms_csr_num = 14'($urandom);
      ms_rj = $urandom; ms_rkd = $urandom; ms_gr_we = 1'($urandom);
      ms_dest = 5'($urandom); ms_result = $urandom;
      ms_excp = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      ms_ertn = ($urandom_range(0, 5) == 0);
      has_int = ($urandom_range(0, 9) == 0);
      redirect_ready = 1'($urandom);
      csr_rdata = $urandom; era = $urandom; eentry = $urandom;
      @(negedge clk);

      ref_cause(m_v, has_int, m_ins.ex, e_any, e_code);
      e_ertn  = m_v && m_ins.ertn && !e_any;
      e_flush = e_any || e_ertn;
      e_allow = !m_redir && !e_flush;
      e_wr    = m_v && !e_flush && (m_ins.op == 2'b10 || m_ins.op == 2'b11);

      chk("rnd_allowin", 32'(ws_allowin), 32'(e_allow));
      chk("rnd_excp_flush", 32'(excp_flush), 32'(e_any));
      chk("rnd_ertn_flush", 32'(ertn_flush), 32'(e_ertn));
      chk("rnd_ws_flush", 32'(ws_flush), 32'(e_flush || m_redir));
      chk("rnd_redirect_valid", 32'(redirect_valid), 32'(m_redir));
      if (m_redir) chk("rnd_redirect_pc", redirect_pc, m_rpc);
      if (e_any) begin
        chk("rnd_ecode", 32'(ecode), 32'(e_code));
        chk("rnd_esubcode", 32'(esubcode), 32'd0);
        chk("rnd_epc", epc, m_ins.pc);
      end
      chk("rnd_csr_we", 32'(csr_we), 32'(e_wr));
      if (e_wr) begin
        chk("rnd_wmask", csr_wmask, (m_ins.op == 2'b11) ? m_ins.rj : 32'hFFFF_FFFF);
        chk("rnd_wdata", csr_wdata, m_ins.rkd);
        chk("rnd_csr_num", 32'(csr_num), 32'(m_ins.num));
      end
      chk("rnd_rf_we", 32'(rf_we), 32'(m_v && m_ins.gr_we && !e_any));
      if (m_v) begin
        chk("rnd_rf_waddr", 32'(rf_waddr), 32'(m_ins.dest));
        chk("rnd_rf_wdata", rf_wdata, (m_ins.op != 2'b00) ? csr_rdata : m_ins.res);
      end

      if (m_redir) begin
        if (redirect_ready) m_redir = 1'b0;
      end else if (e_flush) begin
        m_redir = 1'b1;
        m_rpc   = e_any ? eentry : era;
      end
      m_v = ms_to_ws_valid && e_allow;
      if (m_v)
        m_ins = '{ms_pc, ms_csr_op, ms_csr_num, ms_rj, ms_rkd, ms_gr_we,
                  ms_dest, ms_result, ms_excp, ms_ertn};
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
